// File: rtl/bnn_inference_sequencer.sv
// Stage scheduler for the BNN datapath: LOAD -> L1 -> L2 -> L3 -> DONE.
// Drives the shared state bus, a per-stage watchdog and latches the final class.
module bnn_inference_sequencer #(
    parameter int          TIMEOUT_W     = 16,
    parameter int unsigned STAGE_TIMEOUT = 16'hFFFF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic                 abort,
    input  logic                 load_done,
    input  logic                 layer1_done,
    input  logic                 layer2_done,
    input  logic                 layer3_done,
    input  logic [3:0]           answer_in,
    output logic [2:0]           state,
    output logic                 stage_start,
    output logic                 busy,
    output logic [3:0]           answer,
    output logic                 answer_valid,
    output logic                 error,
    output logic [2:0]           err_stage,
    output logic [TIMEOUT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_L1   = 3'd2,
        S_L2   = 3'd3,
        S_L3   = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(STAGE_TIMEOUT - 1);

    state_t               cur;
    logic                 prev_mode;
    logic                 start;
    logic                 stage_done;
    logic [TIMEOUT_W-1:0] wd;
    logic [TIMEOUT_W-1:0] cnt;

    assign state = cur;
    assign start = mode & ~prev_mode;

    // Only the done line belonging to the current stage is honoured.
    always_comb begin
        stage_done = 1'b0;
        case (cur)
            S_LOAD:  stage_done = load_done;
            S_L1:    stage_done = layer1_done;
            S_L2:    stage_done = layer2_done;
            S_L3:    stage_done = layer3_done;
            default: stage_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur          <= S_IDLE;
            prev_mode    <= 1'b0;
            stage_start  <= 1'b0;
            busy         <= 1'b0;
            answer       <= '0;
            answer_valid <= 1'b0;
            error        <= 1'b0;
            err_stage    <= '0;
            cycle_count  <= '0;
            wd           <= '0;
            cnt          <= '0;
        end else begin
            prev_mode   <= mode;
            stage_start <= 1'b0;
            if (abort) begin
                cur          <= S_IDLE;
                busy         <= 1'b0;
                error        <= 1'b0;
                err_stage    <= '0;
                answer_valid <= 1'b0;
                answer       <= '0;
                wd           <= '0;
            end else begin
                case (cur)
                    S_IDLE: begin
                        if (start) begin
                            cur          <= S_LOAD;
                            busy         <= 1'b1;
                            stage_start  <= 1'b1;
                            answer_valid <= 1'b0;
                            cnt          <= TIMEOUT_W'(1);
                            wd           <= '0;
                        end
                    end
                    S_LOAD, S_L1, S_L2, S_L3: begin
                        if (cnt != '1)
                            cnt <= cnt + 1'b1;
                        // done beats a coincident watchdog expiry
                        if (stage_done) begin
                            wd <= '0;
                            if (cur == S_L3) begin
                                cur          <= S_DONE;
                                busy         <= 1'b0;
                                answer       <= answer_in;
                                answer_valid <= 1'b1;
                                cycle_count  <= cnt;
                            end else begin
                                cur         <= state_t'(cur + 3'd1);
                                stage_start <= 1'b1;
                            end
                        end else if (wd == WD_LAST) begin
                            cur       <= S_ERR;
                            busy      <= 1'b0;
                            error     <= 1'b1;
                            err_stage <= cur;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end
                    S_DONE:  cur <= S_IDLE;
                    S_ERR:   cur <= S_ERR;
                    default: begin
                        cur  <= S_IDLE;
                        busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bnn_inference_sequencer.sv
// Randomized bench: each inference is described by per-stage durations and
// the expected cycle-by-cycle trace is derived from those durations.
module tb_bnn_inference_sequencer;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n, mode, abort;
    logic        load_done, layer1_done, layer2_done, layer3_done;
    logic [3:0]  answer_in;
    logic [2:0]  state;
    logic        stage_start, busy, answer_valid, error;
    logic [3:0]  answer;
    logic [2:0]  err_stage;
    logic [15:0] cycle_count;

    int          errs = 0;
    int          checks = 0;
    int          dur [4];
    logic [3:0]  exp_ans;
    logic        exp_av;

    bnn_inference_sequencer #(.TIMEOUT_W(16), .STAGE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .abort(abort),
        .load_done(load_done), .layer1_done(layer1_done),
        .layer2_done(layer2_done), .layer3_done(layer3_done),
        .answer_in(answer_in), .state(state), .stage_start(stage_start),
        .busy(busy), .answer(answer), .answer_valid(answer_valid),
        .error(error), .err_stage(err_stage), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Stage stg's own done line gets hit; every other line is random noise.
    task automatic set_dones(input int stg, input logic hit);
        load_done   = (stg == 0) ? hit : 1'($urandom_range(0, 1));
        layer1_done = (stg == 1) ? hit : 1'($urandom_range(0, 1));
        layer2_done = (stg == 2) ? hit : 1'($urandom_range(0, 1));
        layer3_done = (stg == 3) ? hit : 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_inf(input logic [3:0] a, input int abort_at);
        int cyc;
        int len;
        mode = 1'b0; abort = 1'b0; set_dones(-1, 1'b0); answer_in = 4'($urandom);
        tick();
        chk("idle_state", state, 0);
        chk("idle_busy", busy, 0);
        chk("idle_av", answer_valid, exp_av);
        if (exp_av) chk("idle_answer", answer, exp_ans);
        mode = 1'b1;
        tick();
        exp_av = 1'b0;
        cyc = 0;
        for (int i = 0; i < 4; i++) begin
            len = (dur[i] <= TO) ? dur[i] : TO;
            for (int k = 1; k <= len; k++) begin
                cyc++;
                chk("stage_state", state, i + 1);
                chk("stage_start", stage_start, (k == 1));
                chk("stage_busy", busy, 1);
                chk("stage_error", error, 0);
                chk("stage_av", answer_valid, 0);
                if (cyc == abort_at) begin
                    abort = 1'b1; mode = 1'($urandom_range(0, 1));
                    set_dones(i, 1'($urandom_range(0, 1)));
                    tick();
                    abort = 1'b0; mode = 1'b0;
                    chk("abort_state", state, 0);
                    chk("abort_start", stage_start, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_error", error, 0);
                    chk("abort_av", answer_valid, 0);
                    chk("abort_answer", answer, 0);
                    exp_av = 1'b0; exp_ans = 4'd0;
                    return;
                end
                set_dones(i, (k == dur[i]));
                mode = 1'($urandom_range(0, 1));
                answer_in = (i == 3 && k == dur[i]) ? a : 4'($urandom);
                tick();
            end
            if (dur[i] > TO) begin
                for (int h = 0; h < 4; h++) begin
                    chk("err_state", state, 6);
                    chk("err_flag", error, 1);
                    chk("err_stage", err_stage, i + 1);
                    chk("err_busy", busy, 0);
                    chk("err_start", stage_start, 0);
                    mode = (h == 3) ? 1'b0 : 1'($urandom_range(0, 1));
                    set_dones(-1, 1'b0);
                    tick();
                end
                chk("err_hold", state, 6);
                abort = 1'b1; mode = 1'b1;
                tick();
                abort = 1'b0;
                chk("clr_state", state, 0);
                chk("clr_error", error, 0);
                chk("clr_err_stage", err_stage, 0);
                chk("clr_av", answer_valid, 0);
                exp_av = 1'b0; exp_ans = 4'd0;
                tick();
                chk("no_restart", state, 0);
                mode = 1'b0;
                return;
            end
        end
        chk("done_state", state, 5);
        chk("done_av", answer_valid, 1);
        chk("done_answer", answer, a);
        chk("done_cycles", cycle_count, cyc);
        chk("done_busy", busy, 0);
        chk("done_start", stage_start, 0);
        mode = 1'b0; set_dones(-1, 1'b0);
        tick();
        chk("post_state", state, 0);
        chk("post_av", answer_valid, 1);
        chk("post_answer", answer, a);
        chk("post_cycles", cycle_count, cyc);
        exp_av = 1'b1; exp_ans = a;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; abort = 1'b0; answer_in = 4'd0;
        load_done = 1'b0; layer1_done = 1'b0; layer2_done = 1'b0; layer3_done = 1'b0;
        exp_av = 1'b0; exp_ans = 4'd0;
        repeat (2) tick();
        chk("rst_state", state, 0);
        chk("rst_start", stage_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_av", answer_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_answer", answer, 0);
        chk("rst_err_stage", err_stage, 0);
        chk("rst_cycles", cycle_count, 0);
        @(negedge clk) rst_n = 1'b1;

        dur = '{5, 3, 2, 4};  run_inf(4'd7, 0);
        chk("nominal_cycles", cycle_count, 14);
        dur = '{2, 1, 3, 1};  run_inf(4'd3, 0);
        chk("b2b_cycles", cycle_count, 7);
        dur = '{3, 40, 1, 1}; run_inf(4'd0, 0);
        dur = '{1, 1, 1, 16}; run_inf(4'd9, 0);

        // Asynchronous reset in the middle of L2, mode held high across release.
        mode = 1'b0; set_dones(-1, 1'b0);
        tick();
        load_done = 1'b0; layer1_done = 1'b0; layer2_done = 1'b0; layer3_done = 1'b0;
        mode = 1'b1;
        tick();
        load_done = 1'b1;
        tick();
        load_done = 1'b0; layer1_done = 1'b1;
        tick();
        layer1_done = 1'b0;
        chk("pre_rst_state", state, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_busy", busy, 0);
        chk("arst_av", answer_valid, 0);
        chk("arst_answer", answer, 0);
        chk("arst_cycles", cycle_count, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rel_state", state, 1);
        chk("rel_start", stage_start, 1);
        abort = 1'b1; mode = 1'b0;
        tick();
        abort = 1'b0;
        chk("rel_abort", state, 0);
        exp_av = 1'b0; exp_ans = 4'd0;

        repeat (40) begin
            for (int i = 0; i < 4; i++)
                dur[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18))
                                                     : int'($urandom_range(1, 6));
            run_inf(4'($urandom),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 10)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
